fir_peak_monitor: RTL and testbench
===================================

Name: fir_peak_monitor

Overview:
- Hardware output-side measurement block for the parallel FIR filters; consumes the LANES-wide `outp` bus of a 2- or 3-parallel filter.
- On command it discards a settling interval, then tracks the signed maximum across all lanes over a fixed window of valid samples.
- It reports the peak and its lane through a valid/ready result handshake.
- Moves the peak-magnitude sweep measurement into synthesizable logic, so it can run on-chip or in a self-checking bench.

Parameters:
- DATA_W, 40: width of each signed filter output lane.
- LANES, 2: number of parallel output lanes (2 or 3).
- SETTLE_CYC, 340: valid samples discarded after start.
- WINDOW_CYC, 2000: valid samples included in the peak search; must be >= 1.
- CNT_W, 16: sample counter width; must hold max(SETTLE_CYC, WINDOW_CYC).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a measurement; sampled only in IDLE.
- abort  in  1  cancel an in-progress measurement.
- in_valid  in  1  din lanes carry a valid filter output this cycle.
- din[LANES-1:0]  in  DATA_W each, signed  filter output lanes; index 0 is the earliest sample.
- busy  out  1  high in SETTLE or MEASURE.
- result_valid  out  1  peak/peak_lane hold a completed result.
- result_ready  in  1  consumer accepts the result.
- peak  out  DATA_W signed  maximum sample over the window.
- peak_lane  out  max(1,$clog2(LANES))  lane index where the peak occurred.

Behaviour:
- Reset (async assert, any state):
  - state=IDLE, counter=0.
  - busy=0, result_valid=0, peak=0, peak_lane=0.
  - Release takes effect on the next clk edge.
- IDLE:
  - start=1 -> SETTLE; counter loads 0.
  - If SETTLE_CYC=0, start goes directly to MEASURE.
- SETTLE:
  - Each cycle with in_valid=1 increments the counter; din is ignored.
  - On the edge that accepts valid sample SETTLE_CYC: -> MEASURE, counter cleared.
- MEASURE:
  - First valid cycle: the running peak initialises to the maximum lane of that cycle. Its prior contents are never compared.
  - Later valid cycles: each lane is compared signed against the running peak and replaces it only if strictly greater.
  - Within one cycle, lanes are evaluated in index order 0..LANES-1, so ties go to the lower lane index.
  - Across cycles, an equal later value does not replace the earlier one.
- Cycles with in_valid=0 in SETTLE or MEASURE: no counting, no comparison; din values are ignored entirely.
- End of window: on the edge accepting valid sample WINDOW_CYC (that sample included):
  - -> REPORT.
  - peak/peak_lane are updated on that same edge.
  - result_valid=1 from the following cycle; latency is 0 cycles after the final sample's edge.
- REPORT:
  - result_valid held at 1; peak and peak_lane held stable.
  - start, in_valid and abort are ignored.
  - result_valid & result_ready at a rising edge -> IDLE. result_valid=0 the next cycle.
  - peak/peak_lane retain their values until the next MEASURE first sample.
- busy=1 exactly in SETTLE and MEASURE.
- abort=1 in SETTLE or MEASURE -> IDLE next edge, no result produced.
  - abort has priority over a simultaneous final sample.
  - abort in IDLE/REPORT has no effect.
- start asserted while not IDLE: ignored; no queuing.
- Arithmetic:
  - All comparisons are full DATA_W signed, two's complement; no scaling or saturation.
  - A negative-only window yields a negative peak.
- Counter: never wraps, because the parameter constraint guarantees headroom. Assertion: counter < 2**CNT_W.

Test Plan:
1. Settle exclusion: SETTLE_CYC=4, WINDOW_CYC=8. Drive din={1000,1000} for 4 valid cycles, then values 0..100 -> peak=100; result_valid rises the cycle after the 12th valid sample.
2. Lane tie/ordering: first window cycle din[0]=50, din[1]=50 -> peak_lane=0. Later cycle din[1]=51 -> peak=51, peak_lane=1. Later din[0]=51 -> unchanged (peak_lane=1).
3. Negative window: all window samples in -20..-5 -> peak=-5 (not 0 or a reset value). Repeat with LANES=3 and peak on lane 2 -> peak_lane=2.
4. Valid gaps: deassert in_valid for 3 cycles mid-MEASURE with din=9999 -> 9999 never reported; result after exactly WINDOW_CYC valid samples; busy stays 1 through gaps.
5. Handshake: hold result_ready=0 for 10 cycles -> result_valid and peak stable; start pulses ignored. result_ready=1 -> IDLE; next start runs a fresh measurement.
6. Abort/reset: abort during MEASURE -> busy=0 next cycle, no result_valid. rst_n low mid-SETTLE (asynchronous, between edges) -> all outputs 0 immediately; next start measures normally.

Source files
------------

// File: rtl/fir_peak_monitor.sv
// ---------------------------------------------------------------------------
// fir_peak_monitor
//
// Output-side measurement block for the 2- or 3-parallel FIR filters. After
// a start command it throws away SETTLE_CYC valid output samples (filter
// transient), then searches WINDOW_CYC valid samples, across every lane, for
// the largest signed value. The peak value and the lane it appeared on are
// handed to the consumer through a valid/ready handshake.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         begin a measurement (honoured only while idle)
//   abort         cancel a measurement in the settle or measure phase
//   in_valid      din carries a valid filter output this cycle
//   din[LANES]    signed filter output lanes, index 0 = earliest sample
//   busy          high while settling or measuring
//   result_valid  peak / peak_lane hold a completed result
//   result_ready  consumer accepts the result
//   peak          largest sample seen in the window
//   peak_lane     lane index on which that sample appeared
// ---------------------------------------------------------------------------
module fir_peak_monitor #(
  parameter  int DATA_W     = 40,
  parameter  int LANES      = 2,
  parameter  int SETTLE_CYC = 340,
  parameter  int WINDOW_CYC = 2000,
  parameter  int CNT_W      = 16,
  localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] din [LANES-1:0],
  output logic                     busy,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic signed [DATA_W-1:0] peak,
  output logic        [LANE_W-1:0] peak_lane
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_REPORT
  } state_e;

  // Counter values that mark the last sample of each phase. The counter
  // counts accepted samples from zero, so sample N is accepted at N-1.
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    (SETTLE_CYC > 0) ? CNT_W'(SETTLE_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_CYC - 1);

  state_e                     state_q, state_d;
  logic        [CNT_W-1:0]    cnt_q, cnt_d;
  logic signed [DATA_W-1:0]   peak_q, peak_d;
  logic        [LANE_W-1:0]   lane_q, lane_d;

  // A sample is taken into the search only when it is valid and the
  // measurement is not being cancelled on the same edge.
  logic take_settle;
  logic take_measure;
  logic first_sample;

  assign take_settle  = (state_q == S_SETTLE)  && in_valid && !abort;
  assign take_measure = (state_q == S_MEASURE) && in_valid && !abort;
  // The counter is cleared on entry to MEASURE, so zero marks the first
  // window sample; the running peak is seeded from it, not compared.
  assign first_sample = (cnt_q == '0);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of the others, independent of process
  // evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: each combinational output is given a default before the case, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (SETTLE_CYC == 0) ? S_MEASURE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (in_valid && cnt_q == SETTLE_LAST) begin
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        // abort wins over a simultaneous final sample
        if (abort) begin
          state_d = S_IDLE;
        end else if (in_valid && cnt_q == WINDOW_LAST) begin
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        // result_valid is high throughout REPORT, so ready alone completes
        // the handshake
        if (result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    busy         = (state_q == S_SETTLE) || (state_q == S_MEASURE);
    result_valid = (state_q == S_REPORT);
    peak         = peak_q;
    peak_lane    = lane_q;
  end

  // -------------------------------------------------------------------------
  // Sample counter
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = '0;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          cnt_d = '0;
        end else if (take_settle) begin
          cnt_d = (cnt_q == SETTLE_LAST) ? '0 : cnt_q + 1'b1;
        end
      end
      S_MEASURE: begin
        if (abort) begin
          cnt_d = '0;
        end else if (take_measure) begin
          cnt_d = (cnt_q == WINDOW_LAST) ? '0 : cnt_q + 1'b1;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // -------------------------------------------------------------------------
  // Running peak search
  // -------------------------------------------------------------------------
  // NOTE: blocking assignments here chain the lane comparisons within one
  // cycle: each lane is compared against the best of the lanes before it.
  // Strict '>' keeps the lower lane on a tie, and keeps the earlier sample
  // when a later cycle only equals the running peak.
  always_comb begin
    peak_d = peak_q;
    lane_d = lane_q;
    if (take_measure) begin
      for (int i = 0; i < LANES; i++) begin
        if ((first_sample && i == 0) || din[i] > peak_d) begin
          peak_d = din[i];
          lane_d = LANE_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      peak_q <= '0;
      lane_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      peak_q <= peak_d;
      lane_q <= lane_d;
    end
  end

  // -------------------------------------------------------------------------
  // Counter headroom: the counter never runs past the last index of the
  // phase it is counting, so it cannot wrap.
  // -------------------------------------------------------------------------
  a_cnt_settle : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_SETTLE) |-> (cnt_q <= SETTLE_LAST));
  a_cnt_measure : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_MEASURE) |-> (cnt_q <= WINDOW_LAST));

endmodule

// File: tb/tb_fir_peak_monitor.sv
// ---------------------------------------------------------------------------
// tb_fir_peak_monitor
//
// Two monitors (2 lanes and 3 lanes, settle 4, window 8) share the control
// inputs and lanes 0/1, so they walk through the same phases; only the peak
// they report can differ. A reference model keeps every window sample of the
// current measurement and derives the expected peak by scanning that list
// from the rules: first sample seeds, a later value wins only if strictly
// greater, lanes scanned in index order. A compare process checks all
// outputs of both monitors on every falling edge; directed scenarios add
// hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_fir_peak_monitor;

  localparam int DW = 40;
  localparam int S  = 4;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic in_valid = 1'b0;
  logic result_ready = 1'b0;
  logic signed [DW-1:0] d0 = '0;
  logic signed [DW-1:0] d1 = '0;
  logic signed [DW-1:0] d2 = '0;

  logic signed [DW-1:0] din2 [1:0];
  logic signed [DW-1:0] din3 [2:0];
  assign din2[0] = d0;
  assign din2[1] = d1;
  assign din3[0] = d0;
  assign din3[1] = d1;
  assign din3[2] = d2;

  logic                 busy2, rv2, busy3, rv3;
  logic signed [DW-1:0] peak2, peak3;
  logic                 lane2;
  logic [1:0]           lane3;

  fir_peak_monitor #(
    .DATA_W(DW), .LANES(2), .SETTLE_CYC(S), .WINDOW_CYC(W), .CNT_W(16)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .din(din2), .busy(busy2), .result_valid(rv2),
    .result_ready(result_ready), .peak(peak2), .peak_lane(lane2)
  );

  fir_peak_monitor #(
    .DATA_W(DW), .LANES(3), .SETTLE_CYC(S), .WINDOW_CYC(W), .CNT_W(16)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .din(din3), .busy(busy3), .result_valid(rv3),
    .result_ready(result_ready), .peak(peak3), .peak_lane(lane3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  //   phase 0 = idle, 1 = busy (settle or measure), 2 = result pending
  //   nv    = valid samples accepted since start
  //   q0..2 = window samples of the latest measurement that reached one
  // ---------------------------------------------------------------------------
  int     phase = 0;
  int     nv = 0;
  bit     fresh = 1'b0;
  longint q0[$];
  longint q1[$];
  longint q2[$];

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      phase = 0;
      nv    = 0;
      fresh = 1'b0;
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      case (phase)
        0: if (start) begin
          phase = 1;
          nv    = 0;
          fresh = 1'b1;
        end
        1: if (abort) begin
          phase = 0;
        end else if (in_valid) begin
          nv++;
          if (nv > S) begin
            if (fresh) begin
              q0.delete();
              q1.delete();
              q2.delete();
              fresh = 1'b0;
            end
            q0.push_back(longint'(d0));
            q1.push_back(longint'(d1));
            q2.push_back(longint'(d2));
          end
          if (nv == S + W) phase = 2;
        end
        2: if (result_ready) phase = 0;
        default: phase = 0;
      endcase
    end
  end

  // Expected peak over the stored window samples for an n-lane monitor.
  function automatic void exp_out(input int n, output logic signed [63:0] p,
                                  output int ln);
    longint v;
    p  = 0;
    ln = 0;
    for (int j = 0; j < q0.size(); j++) begin
      for (int i = 0; i < n; i++) begin
        v = (i == 0) ? q0[j] : (i == 1) ? q1[j] : q2[j];
        if ((j == 0 && i == 0) || v > p) begin
          p  = v;
          ln = i;
        end
      end
    end
  endfunction

  // Cycle-by-cycle comparison on the falling edge.
  initial forever begin
    logic signed [63:0] ep;
    int                 el;
    @(negedge clk);
    check("busy2", busy2, phase == 1);
    check("busy3", busy3, phase == 1);
    check("rv2", rv2, phase == 2);
    check("rv3", rv3, phase == 2);
    exp_out(2, ep, el);
    check("peak2", peak2, ep);
    check("lane2", lane2, el);
    exp_out(3, ep, el);
    check("peak3", peak3, ep);
    check("lane3", lane3, el);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step(input bit v, input logic signed [DW-1:0] a,
                      input logic signed [DW-1:0] b,
                      input logic signed [DW-1:0] c);
    in_valid = v;
    d0 = a;
    d1 = b;
    d2 = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    step(1'b0, 0, 0, 0);
    start = 1'b0;
  endtask

  task automatic settle();
    repeat (S) step(1'b1, 1000, 1000, 1000);
  endtask

  // Wait (bounded) for a result, check it against literals, then accept it.
  task automatic take_result(input string tag, input logic signed [63:0] p2,
                             input int l2, input logic signed [63:0] p3,
                             input int l3);
    int k = 0;
    while (!rv2 && k < 40) begin
      step(1'b0, 0, 0, 0);
      k++;
    end
    check({tag, "_rv"}, rv2, 1);
    check({tag, "_peak2"}, peak2, p2);
    check({tag, "_lane2"}, lane2, l2);
    check({tag, "_peak3"}, peak3, p3);
    check({tag, "_lane3"}, lane3, l3);
    result_ready = 1'b1;
    step(1'b0, 0, 0, 0);
    result_ready = 1'b0;
    check({tag, "_rv_clear"}, rv2, 0);
    check({tag, "_idle"}, busy2, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    #1;
    check("rst_busy", busy2, 0);
    check("rst_rv", rv2, 0);
    check("rst_peak", peak2, 0);
    check("rst_lane", lane2, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Settle exclusion: the 1000s are discarded, peak 100 on lane 0.
    go();
    check("t1_busy", busy2, 1);
    settle();
    step(1'b1, 0, 5, -1);
    step(1'b1, 10, 20, -1);
    step(1'b1, 30, 25, -1);
    step(1'b1, 100, 40, -1);
    step(1'b1, 50, 60, -1);
    step(1'b1, 70, 80, -1);
    step(1'b1, 90, 95, -1);
    check("t1_rv_before_last", rv2, 0);
    check("t1_busy_before_last", busy2, 1);
    step(1'b1, 15, 35, -1);
    check("t1_rv_after_last", rv2, 1);
    check("t1_busy_after_last", busy2, 0);
    take_result("t1", 100, 0, 100, 0);

    // Tie and ordering rules, then a held result with ignored inputs.
    go();
    settle();
    step(1'b1, 50, 50, 0);
    check("t2_first_peak", peak2, 50);
    check("t2_first_lane", lane2, 0);
    step(1'b1, 10, 51, 0);
    check("t2_up_lane", lane2, 1);
    step(1'b1, 51, 0, 0);
    check("t2_eq_peak", peak2, 51);
    check("t2_eq_lane", lane2, 1);
    repeat (5) step(1'b1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      abort = (i == 3);
      step(1'b1, 9999, 9999, 9999);
      check("t5_hold_rv", rv2, 1);
      check("t5_hold_peak", peak2, 51);
    end
    start = 1'b0;
    abort = 1'b0;
    take_result("t2", 51, 1, 51, 1);

    // Negative-only window: peak -5 on lane 0 for both widths.
    go();
    settle();
    step(1'b1, -20, -7, -9);
    step(1'b1, -12, -6, -15);
    step(1'b1, -5, -18, -8);
    step(1'b1, -10, -11, -6);
    step(1'b1, -19, -13, -14);
    step(1'b1, -7, -5, -20);
    step(1'b1, -16, -17, -10);
    step(1'b1, -8, -9, -11);
    take_result("t3a", -5, 0, -5, 0);

    // Negative window, lane 2 highest, with a gap of invalid 9999 samples.
    go();
    settle();
    step(1'b1, -20, -9, -12);
    step(1'b1, -7, -15, -10);
    step(1'b1, -11, -8, -5);
    repeat (3) begin
      step(1'b0, 9999, 9999, 9999);
      check("t4_gap_busy", busy2, 1);
    end
    step(1'b1, -13, -14, -6);
    step(1'b1, -10, -12, -9);
    step(1'b1, -18, -7, -8);
    step(1'b1, -9, -16, -11);
    check("t4_rv_before_last", rv2, 0);
    step(1'b1, -12, -10, -15);
    check("t4_rv_after_last", rv2, 1);
    take_result("t3b", -7, 0, -5, 2);

    // Abort mid-window.
    go();
    settle();
    step(1'b1, 3, 4, 5);
    step(1'b1, 6, 7, 8);
    abort = 1'b1;
    step(1'b0, 0, 0, 0);
    abort = 1'b0;
    check("t6_abort_busy", busy2, 0);
    check("t6_abort_rv", rv2, 0);
    repeat (3) step(1'b0, 0, 0, 0);
    check("t6_abort_no_result", rv2, 0);

    // Abort together with the final window sample: no result.
    go();
    settle();
    for (int i = 1; i <= 7; i++) step(1'b1, 10 * i, 0, 0);
    abort = 1'b1;
    step(1'b1, 500, 500, 500);
    abort = 1'b0;
    check("t6_final_abort_rv", rv2, 0);
    check("t6_final_abort_busy", busy2, 0);
    check("t6_final_abort_peak", peak2, 70);

    // Asynchronous reset mid-settle, between clock edges.
    go();
    step(1'b1, 1000, 1000, 1000);
    step(1'b1, 1000, 1000, 1000);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy2, 0);
    check("t6_rst_rv", rv2, 0);
    check("t6_rst_peak", peak2, 0);
    check("t6_rst_lane", lane2, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    go();
    settle();
    for (int i = 1; i <= 8; i++) step(1'b1, i, 9 - i, 3);
    take_result("t6_after_rst", 8, 1, 8, 1);

    repeat (2) step(1'b0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
